sdram_ring_handler: RTL and testbench

SDRAM_RING_HANDLER -- requirements
Module: sdram_ring_handler

---
 rtl/sdram_ring_handler_if.sv | 42 ++++
 rtl/sdram_ring_handler.sv | 149 ++++++++++++++
 tb/tb_sdram_ring_handler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_ring_handler_if.sv
// Bundle of the stream FIFOs, SDRAM core request/completion and register ports
// seen by sdram_ring_handler.
interface sdram_ring_handler_if #(
  parameter int DW = 16,
  parameter int AW = 24
);
  logic          w_empty;
  logic [DW-1:0] w_data;
  logic          w_en;
  logic          r_almost_full;
  logic          r_en;
  logic [DW-1:0] r_data;
  logic          rprio;
  logic          mem_avalid;
  logic          mem_aready;
  logic          mem_awe;
  logic [AW-1:0] mem_aaddr;
  logic [DW-1:0] mem_adata;
  logic          mem_bvalid;
  logic          mem_bwe;
  logic [DW-1:0] mem_bdata;
  logic          avalid;
  logic          awe;
  logic [2:0]    aaddr;
  logic [31:0]   adata;
  logic          bvalid;
  logic [31:0]   bdata;

  modport slave (
    input  w_empty, w_data, r_almost_full, rprio, mem_aready,
           mem_bvalid, mem_bwe, mem_bdata, avalid, awe, aaddr, adata,
    output w_en, r_en, r_data, mem_avalid, mem_awe, mem_aaddr, mem_adata,
           bvalid, bdata
  );

  modport master (
    output w_empty, w_data, r_almost_full, rprio, mem_aready,
           mem_bvalid, mem_bwe, mem_bdata, avalid, awe, aaddr, adata,
    input  w_en, r_en, r_data, mem_avalid, mem_awe, mem_aaddr, mem_adata,
           bvalid, bdata
  );
endinterface

// File: rtl/sdram_ring_handler.sv
// Streams captured words into an SDRAM ring buffer [BASE, LIMIT) and issues
// readback requests, arbitrating both onto a single SDRAM core request port.
module sdram_ring_handler #(
  parameter int DW = 16,
  parameter int AW = 24,
  parameter int CW = 24,
  parameter int TW = 3
) (
  input  logic               clk,
  input  logic               rst,
  sdram_ring_handler_if.slave bus
);

  logic [AW-1:0] r_waddr, r_cwaddr, r_raddr, r_base, r_limit, r_fill;
  logic [CW-1:0] r_rcount;
  logic [TW-1:0] r_inflight;
  logic [2:0]    r_ctrl;
  logic          r_ovf, r_wrap, r_tog, r_bvalid;
  logic [31:0]   r_bdata;

  logic [AW-1:0] w_size;
  logic          w_ring, w_full, w_wable, w_rable, w_rsel, w_contest;
  logic          w_req, w_acc, w_accw, w_accr, w_cmp, w_busy;
  logic          w_wr, w_clr, w_rewind;
  logic [AW:0]   w_wadv, w_cadv, w_radv;
  logic [31:0]   w_rd;

  assign w_size = r_limit - r_base;
  assign w_ring = r_base < r_limit;
  assign w_full = r_fill == w_size;

  // Returns {wrapped, next}; a malformed ring degrades to plain modulo-2^AW counting.
  function automatic logic [AW:0] adv(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    n = p + 1'b1;
    if (w_ring && n == r_limit) return {1'b1, r_base};
    return {1'b0, n};
  endfunction

  assign w_wadv = adv(r_waddr);
  assign w_cadv = adv(r_cwaddr);
  assign w_radv = adv(r_raddr);

  assign w_wable = !bus.w_empty && r_ctrl[0] && (r_inflight != {TW{1'b1}}) &&
                   !(r_ctrl[1] && w_full);
  assign w_rable = (r_rcount != '0) && !bus.r_almost_full;
  assign w_contest = w_wable && w_rable && !(bus.rprio || r_ctrl[2]);

  always_comb begin
    w_rsel = w_rable;
    if (w_wable && w_rable) w_rsel = bus.rprio || r_ctrl[2] || r_tog;
  end

  assign w_req  = (w_wable || w_rable) && !rst;
  assign w_acc  = w_req && bus.mem_aready;
  assign w_accw = w_acc && !w_rsel;
  assign w_accr = w_acc && w_rsel;
  assign w_cmp  = bus.mem_bvalid && bus.mem_bwe;
  assign w_busy = w_wable || (r_inflight != '0);

  assign bus.mem_avalid = w_req;
  assign bus.mem_awe    = !w_rsel;
  assign bus.mem_aaddr  = w_rsel ? r_raddr : r_waddr;
  assign bus.mem_adata  = bus.w_data;
  assign bus.w_en       = w_accw;
  assign bus.r_en       = bus.mem_bvalid && !bus.mem_bwe && !rst;
  assign bus.r_data     = bus.mem_bdata;
  assign bus.bvalid     = r_bvalid;
  assign bus.bdata      = r_bdata;

  assign w_wr     = bus.avalid && bus.awe;
  assign w_clr    = w_wr && bus.aaddr == 3'd5 && bus.adata[3];
  assign w_rewind = w_wr && bus.aaddr == 3'd5 && bus.adata[4];

  always_comb begin
    w_rd = '0;
    case (bus.aaddr)
      3'd0: w_rd = 32'(r_raddr);
      3'd1: w_rd = 32'(r_rcount);
      3'd2: w_rd = 32'(r_base);
      3'd3: w_rd = 32'(r_limit);
      3'd4: w_rd = {w_busy, r_ovf, r_wrap, 5'b0, 24'(r_cwaddr)};
      3'd5: w_rd = 32'(r_ctrl);
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr    <= '0;
      r_cwaddr   <= '0;
      r_raddr    <= '0;
      r_rcount   <= '0;
      r_base     <= '0;
      r_limit    <= '1;
      r_fill     <= '0;
      r_inflight <= '0;
      r_ctrl     <= '0;
      r_ovf      <= 1'b0;
      r_wrap     <= 1'b0;
      r_tog      <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bdata    <= '0;
    end else begin
      r_bvalid <= bus.avalid;
      if (bus.avalid) r_bdata <= w_rd;
      if (w_contest && w_acc) r_tog <= ~r_tog;

      if (w_accw) begin
        r_waddr <= w_wadv[AW-1:0];
        if (!w_full) r_fill <= r_fill + 1'b1;
      end
      if (w_accr) begin
        r_raddr  <= w_radv[AW-1:0];
        r_rcount <= r_rcount - 1'b1;
        if (r_fill != '0) r_fill <= r_fill - 1'b1;
      end
      if (w_cmp) r_cwaddr <= w_cadv[AW-1:0];

      // A same-cycle set beats the software clear.
      r_ovf  <= (r_ovf && !w_clr) || (w_accw && w_full);
      r_wrap <= (r_wrap && !w_clr) || (w_accw && w_wadv[AW]);

      case ({w_accw, w_cmp})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase

      // Software writes land last so they override any same-cycle pointer update.
      if (w_wr) begin
        case (bus.aaddr)
          3'd0: r_raddr  <= AW'(bus.adata);
          3'd1: r_rcount <= CW'(bus.adata);
          3'd2: r_base   <= AW'(bus.adata);
          3'd3: r_limit  <= AW'(bus.adata);
          3'd5: r_ctrl   <= bus.adata[2:0];
          default: ;
        endcase
      end
      if (w_rewind) begin
        r_waddr  <= r_base;
        r_cwaddr <= r_base;
        r_fill   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_ring_handler.sv
// Directed bench: register table plus ring/arbitration sequences against a
// capture FIFO queue and a fixed-latency SDRAM completion model.
module tb_sdram_ring_handler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_ring_handler_if #(.DW(16), .AW(24)) ifc();
  sdram_ring_handler #(.DW(16), .AW(24), .CW(24), .TW(3)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  typedef struct { bit we; logic [23:0] addr; logic [15:0] data; } grant_t;
  typedef struct { int due; bit we; logic [15:0] d; } cmp_t;
  typedef struct { bit we; logic [2:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;

  grant_t      glog[$];
  cmp_t        cq[$];
  logic [15:0] wq[$];
  vec_t        tv[$];
  int          checks = 0, errors = 0, cyc_n = 0, n_wen = 0, n_ren = 0;
  logic [15:0] last_rd;
  bit          s_wen_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: drive FIFO/completion inputs, sample combinational outputs, commit.
  task automatic step();
    bit dlv, s_wen, s_acc, s_we, s_ren;
    logic [23:0] s_a;
    logic [15:0] s_d, s_rd;
    ifc.w_empty = (wq.size() == 0);
    ifc.w_data  = (wq.size() != 0) ? wq[0] : 16'h0;
    dlv = (cq.size() != 0) && (cq[0].due <= cyc_n);
    ifc.mem_bvalid = dlv;
    ifc.mem_bwe    = dlv ? cq[0].we : 1'b0;
    ifc.mem_bdata  = dlv ? cq[0].d : 16'h0;
    #1;
    s_wen = ifc.w_en;
    s_acc = ifc.mem_avalid && ifc.mem_aready;
    s_we  = ifc.mem_awe;
    s_a   = ifc.mem_aaddr;
    s_d   = ifc.mem_adata;
    s_ren = ifc.r_en;
    s_rd  = ifc.r_data;
    chk("w_en_rule", {31'b0, s_wen}, {31'b0, s_acc && s_we});
    @(posedge clk); #1;
    cyc_n++;
    if (s_wen) begin n_wen++; wq.delete(0); end
    if (dlv) cq.delete(0);
    if (s_ren) begin n_ren++; last_rd = s_rd; end
    if (s_acc) begin
      glog.push_back('{s_we, s_a, s_d});
      cq.push_back('{cyc_n + 1, s_we, s_we ? 16'h0 : (16'hA000 ^ s_a[15:0])});
    end
    s_wen_last = s_wen;
  endtask

  task automatic reg_op(input bit we, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] q);
    ifc.avalid = 1'b1; ifc.awe = we; ifc.aaddr = a; ifc.adata = d;
    step();
    chk("bvalid", {31'b0, ifc.bvalid}, 32'd1);
    q = ifc.bdata;
    ifc.avalid = 1'b0; ifc.awe = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    reg_op(1'b1, a, d, q);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] q;
    reg_op(1'b0, a, 32'h0, q);
    chk(nm, q, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.mem_bvalid = 1'b1; ifc.mem_bwe = 1'b0; ifc.mem_bdata = 16'h0;
    ifc.w_empty = 1'b0; ifc.w_data = 16'h0;
    ifc.avalid = 1'b0; ifc.awe = 1'b0; ifc.aaddr = 3'd0; ifc.adata = 32'h0;
    ifc.mem_aready = 1'b1; ifc.r_almost_full = 1'b1; ifc.rprio = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_avalid", {31'b0, ifc.mem_avalid}, 32'd0);
    chk("rst_r_en", {31'b0, ifc.r_en}, 32'd0);
    chk("rst_w_en", {31'b0, ifc.w_en}, 32'd0);
    rst = 1'b0; ifc.mem_bvalid = 1'b0;
    wq.delete(); cq.delete(); glog.delete();
    n_wen = 0; n_ren = 0;
  endtask

  task automatic check_pattern(input string nm, input bit [6:0] exp_we, input int n);
    for (int i = 0; i < n; i++)
      if (i < glog.size()) chk(nm, {31'b0, glog[i].we}, {31'b0, exp_we[6-i]});
      else chk({nm, "_missing"}, glog.size(), n);
  endtask

  initial begin
    // Register map after reset, readback, truncation and self-clearing CTRL bits.
    tv.push_back('{1'b0, 3'd0, 32'h0, 32'h0});
    tv.push_back('{1'b0, 3'd1, 32'h0, 32'h0});
    tv.push_back('{1'b0, 3'd2, 32'h0, 32'h0});
    tv.push_back('{1'b0, 3'd3, 32'h0, 32'h00FF_FFFF});
    tv.push_back('{1'b0, 3'd4, 32'h0, 32'h0});
    tv.push_back('{1'b0, 3'd5, 32'h0, 32'h0});
    tv.push_back('{1'b0, 3'd6, 32'h0, 32'h0});
    tv.push_back('{1'b0, 3'd7, 32'h0, 32'h0});
    tv.push_back('{1'b1, 3'd0, 32'h55, 32'h0});
    tv.push_back('{1'b0, 3'd0, 32'h0, 32'h55});
    tv.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0});
    tv.push_back('{1'b0, 3'd0, 32'h0, 32'h00FF_FFFF});
    tv.push_back('{1'b1, 3'd1, 32'h1234, 32'h0});
    tv.push_back('{1'b0, 3'd1, 32'h0, 32'h1234});
    tv.push_back('{1'b1, 3'd2, 32'h123, 32'h0});
    tv.push_back('{1'b0, 3'd2, 32'h0, 32'h123});
    tv.push_back('{1'b1, 3'd3, 32'h456, 32'h0});
    tv.push_back('{1'b0, 3'd3, 32'h0, 32'h456});
    tv.push_back('{1'b1, 3'd5, 32'h1F, 32'h0});
    tv.push_back('{1'b0, 3'd5, 32'h0, 32'h7});
    tv.push_back('{1'b0, 3'd4, 32'h0, 32'h123});
    tv.push_back('{1'b1, 3'd6, 32'hFFFF, 32'h0});
    tv.push_back('{1'b0, 3'd6, 32'h0, 32'h0});
    tv.push_back('{1'b1, 3'd5, 32'h0, 32'h0});

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      logic [31:0] q;
      reg_op(tv[i].we, tv[i].a, tv[i].d, q);
      if (!tv[i].we) chk($sformatf("reg%0d_vec%0d", tv[i].a, i), q, tv[i].exp);
    end
    step();
    chk("bvalid_drop", {31'b0, ifc.bvalid}, 32'd0);

    // Plain linear streaming from address 0.
    do_reset();
    wr(3'd5, 32'h1);
    for (int i = 0; i < 4; i++) wq.push_back(16'(16'h1111 * (i + 1)));
    rd(3'd4, 32'h8000_0000, "status_busy");
    repeat (12) step();
    chk("lin_grants", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      chk("lin_we", {31'b0, glog[i].we}, 32'd1);
      chk("lin_addr", {8'b0, glog[i].addr}, i);
      chk("lin_data", {16'b0, glog[i].data}, {16'b0, 16'(16'h1111 * (i + 1))});
    end
    chk("lin_w_en_cnt", n_wen, 4);
    rd(3'd4, 32'h0000_0004, "lin_status_done");

    // Two-word ring, overwrite mode: wrap and overflow, then sticky clear.
    do_reset();
    wr(3'd2, 32'h10); wr(3'd3, 32'h12); wr(3'd5, 32'h11);
    for (int i = 0; i < 3; i++) wq.push_back(16'(i + 16'h40));
    repeat (10) step();
    chk("ring_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("ring_a0", {8'b0, glog[0].addr}, 32'h10);
      chk("ring_a1", {8'b0, glog[1].addr}, 32'h11);
      chk("ring_a2", {8'b0, glog[2].addr}, 32'h10);
    end
    rd(3'd4, 32'h6000_0011, "ring_status");
    wr(3'd5, 32'h09);
    rd(3'd4, 32'h0000_0011, "ring_cleared");
    rd(3'd5, 32'h1, "ring_ctrl");

    // Two-word ring with STOP: third word waits for a read to free space.
    do_reset();
    wr(3'd2, 32'h10); wr(3'd3, 32'h12); wr(3'd5, 32'h13);
    for (int i = 0; i < 3; i++) wq.push_back(16'(i + 16'h70));
    repeat (8) step();
    chk("stop_grants", glog.size(), 2);
    chk("stop_held", wq.size(), 1);
    chk("stop_w_en_low", {31'b0, s_wen_last}, 32'd0);
    ifc.r_almost_full = 1'b0;
    wr(3'd1, 32'h1);
    repeat (8) step();
    chk("stop_grants2", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("stop_rd_we", {31'b0, glog[2].we}, 32'd0);
      chk("stop_rd_addr", {8'b0, glog[2].addr}, 32'h0);
      chk("stop_w3_we", {31'b0, glog[3].we}, 32'd1);
      chk("stop_w3_addr", {8'b0, glog[3].addr}, 32'h10);
    end
    chk("stop_r_en_cnt", n_ren, 1);
    chk("stop_r_data", {16'b0, last_rd}, 32'hA000);

    // Fair alternation, then read priority.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      wr(3'd1, 32'h3);
      for (int i = 0; i < 8; i++) wq.push_back(16'(i));
      wr(3'd5, 32'h1);
      ifc.rprio = (p == 1);
      ifc.r_almost_full = 1'b0;
      repeat (16) step();
      chk(p ? "prio_total" : "alt_total", glog.size(), 11);
      if (p == 0) begin
        check_pattern("alt_order", 7'b1010101, 7);
        if (glog.size() > 5) chk("alt_raddr2", {8'b0, glog[5].addr}, 32'h2);
      end else begin
        check_pattern("prio_order", 7'b0001111, 7);
        if (glog.size() > 3) chk("prio_waddr0", {8'b0, glog[3].addr}, 32'h0);
      end
      ifc.rprio = 1'b0;
    end

    // Software RCOUNT write beats a same-cycle read accept.
    do_reset();
    wr(3'd1, 32'h2);
    ifc.r_almost_full = 1'b0;
    wr(3'd1, 32'h5);
    ifc.r_almost_full = 1'b1;
    rd(3'd1, 32'h5, "rcount_wins");
    rd(3'd0, 32'h1, "raddr_advanced");
    chk("coll_grants", glog.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
